// File: rtl/sdram_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the sdram_block host port.
// Valid/ready: a request is taken in the cycle where reqN_valid and reqN_ready are both 1; until then the requester holds every request field stable, and it may drop valid instead.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wr_data;
    logic              req0_we;
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_rsp_data;
    logic              req0_rsp_valid;
    logic              req0_rsp_err;

    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wr_data;
    logic              req1_we;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_rsp_data;
    logic              req1_rsp_valid;
    logic              req1_rsp_err;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_wr_en;
    logic              ram_rd_en;
    logic              ram_busy;
    logic              ram_rd_ready;
    logic [DATA_W-1:0] ram_rd_data;
    logic              ram_rd_ack;

    modport slave (
        input  req0_addr, req0_wr_data, req0_we, req0_valid,
        output req0_ready, req0_rsp_data, req0_rsp_valid, req0_rsp_err,
        input  req1_addr, req1_wr_data, req1_we, req1_valid,
        output req1_ready, req1_rsp_data, req1_rsp_valid, req1_rsp_err,
        output ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_ack,
        input  ram_busy, ram_rd_ready, ram_rd_data
    );

    modport master (
        output req0_addr, req0_wr_data, req0_we, req0_valid,
        input  req0_ready, req0_rsp_data, req0_rsp_valid, req0_rsp_err,
        output req1_addr, req1_wr_data, req1_we, req1_valid,
        input  req1_ready, req1_rsp_data, req1_rsp_valid, req1_rsp_err,
        input  ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_ack,
        output ram_busy, ram_rd_ready, ram_rd_data
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing the sdram_block host port between CPU (req0) and DMA (req1).
// Optional read timeout with stale-entry discard is enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    sdram_arbiter_if.slave bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    state_t state, state_n;
    logic   rr_ptr;
    logic   owner_q;
    logic   we_q;
    logic   grant;
    logic   owner_n;
    logic   rd_seen;
    logic   stale_hit;
    logic   timeout_hit;

    // While ack is high the FIFO head is the entry being popped, so its ready is not new data.
    assign rd_seen   = bus.ram_rd_ready && !bus.ram_rd_ack;
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        owner_n = 1'b0;
        case (state)
            IDLE: begin
                if (!stale_hit && !bus.ram_busy && (bus.req0_valid || bus.req1_valid)) begin
                    grant   = 1'b1;
                    owner_n = (bus.req0_valid && bus.req1_valid) ? ~rr_ptr : bus.req1_valid;
                    state_n = ISSUE;
                end
            end
            ISSUE:   state_n = we_q ? IDLE : RD_WAIT;
            RD_WAIT: begin
                if (stale_hit)
                    state_n = RD_WAIT;
                else if (rd_seen)
                    state_n = RD_DONE;
                else if (timeout_hit)
                    state_n = IDLE;
            end
            RD_DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.req0_ready = grant && !owner_n && rst;
    assign bus.req1_ready = grant && owner_n && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            rr_ptr             <= 1'b1;
            owner_q            <= 1'b0;
            we_q               <= 1'b0;
            bus.ram_addr       <= '0;
            bus.ram_wr_data    <= '0;
            bus.ram_wr_en      <= 1'b0;
            bus.ram_rd_en      <= 1'b0;
            bus.ram_rd_ack     <= 1'b0;
            bus.req0_rsp_data  <= '0;
            bus.req1_rsp_data  <= '0;
            bus.req0_rsp_valid <= 1'b0;
            bus.req1_rsp_valid <= 1'b0;
        end else begin
            state              <= state_n;
            bus.ram_wr_en      <= 1'b0;
            bus.ram_rd_en      <= 1'b0;
            bus.ram_rd_ack     <= 1'b0;
            bus.req0_rsp_valid <= 1'b0;
            bus.req1_rsp_valid <= 1'b0;
            if (grant) begin
                owner_q         <= owner_n;
                rr_ptr          <= owner_n;
                we_q            <= owner_n ? bus.req1_we : bus.req0_we;
                bus.ram_addr    <= owner_n ? bus.req1_addr : bus.req0_addr;
                bus.ram_wr_data <= owner_n ? bus.req1_wr_data : bus.req0_wr_data;
                bus.ram_wr_en   <= owner_n ? bus.req1_we : bus.req0_we;
                bus.ram_rd_en   <= owner_n ? !bus.req1_we : !bus.req0_we;
            end
            if (state == RD_WAIT && rd_seen && !stale_hit) begin
                bus.ram_rd_ack <= 1'b1;
                if (owner_q) begin
                    bus.req1_rsp_data  <= bus.ram_rd_data;
                    bus.req1_rsp_valid <= 1'b1;
                end else begin
                    bus.req0_rsp_data  <= bus.ram_rd_data;
                    bus.req0_rsp_valid <= 1'b1;
                end
            end
            if (stale_hit)
                bus.ram_rd_ack <= 1'b1;
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             stale;
    logic [CNT_W-1:0] wait_cnt;

    // A timed-out read leaves one orphan entry in the read FIFO; it is popped on first sight.
    assign stale_hit   = stale && rd_seen && (state == IDLE || state == RD_WAIT);
    assign timeout_hit = (state == RD_WAIT) && !rd_seen &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stale            <= 1'b0;
            wait_cnt         <= '0;
            bus.req0_rsp_err <= 1'b0;
            bus.req1_rsp_err <= 1'b0;
        end else begin
            bus.req0_rsp_err <= 1'b0;
            bus.req1_rsp_err <= 1'b0;
            if (state != RD_WAIT || stale_hit)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (stale_hit) begin
                stale <= 1'b0;
            end else if (timeout_hit) begin
                stale <= 1'b1;
                if (owner_q)
                    bus.req1_rsp_err <= 1'b1;
                else
                    bus.req0_rsp_err <= 1'b1;
            end
        end
    end
`else
    assign stale_hit        = 1'b0;
    assign timeout_hit      = 1'b0;
    assign bus.req0_rsp_err = 1'b0;
    assign bus.req1_rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a transaction-timing model checked every cycle, plus literal spot checks.
// A small SDRAM read-FIFO model returns data a programmable number of cycles after each read strobe.
module tb_sdram_arbiter;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int TO     = 8;
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "bench stopped");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- SDRAM read-FIFO model ----------------
    int               rq_due[$];
    logic [DATA_W-1:0] rq_dat[$];
    int               ram_lat = 5;
    logic [DATA_W-1:0] ram_dat = 16'h1234;

    initial begin
        bus.ram_busy     = 1'b0;
        bus.ram_rd_ready = 1'b0;
        bus.ram_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rq_due.delete();
                rq_dat.delete();
            end else begin
                if (bus.ram_rd_ack && rq_due.size() > 0) begin
                    void'(rq_due.pop_front());
                    void'(rq_dat.pop_front());
                end
                if (bus.ram_rd_en) begin
                    rq_due.push_back(cyc + ram_lat);
                    rq_dat.push_back(ram_dat);
                end
            end
            @(posedge clk);
            #1;
            if (rq_due.size() > 0 && cyc >= rq_due[0]) begin
                bus.ram_rd_ready = 1'b1;
                bus.ram_rd_data  = rq_dat[0];
            end else begin
                bus.ram_rd_ready = 1'b0;
                bus.ram_rd_data  = '0;
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    int                m_ptr, m_owner, m_accept_ok, m_issue_cyc, m_wait_from;
    int                m_done_cyc, m_ack_cyc, m_err_cyc;
    bit                m_wait, m_we, m_stale;
    logic [ADDR_W-1:0] m_addr, m_addr_n;
    logic [DATA_W-1:0] m_wdata, m_wdata_n;
    logic [DATA_W-1:0] m_rsp0, m_rsp1, m_rsp0_n, m_rsp1_n;
    int                glog[$];
    int                ack_count = 0;
    bit                e_idle, e_wait, e_rd_seen, e_stale_take, e_acc;
    int                e_w;

    task automatic model_reset();
        m_ptr = 1; m_owner = 0; m_accept_ok = 0; m_issue_cyc = -10; m_wait_from = -10;
        m_done_cyc = -10; m_ack_cyc = -10; m_err_cyc = -10;
        m_wait = 0; m_we = 0; m_stale = 0;
        m_addr = '0; m_addr_n = '0; m_wdata = '0; m_wdata_n = '0;
        m_rsp0 = '0; m_rsp1 = '0; m_rsp0_n = '0; m_rsp1_n = '0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            model_reset();
            check("rst_ready0", bus.req0_ready, 0);
            check("rst_ready1", bus.req1_ready, 0);
            check("rst_addr", bus.ram_addr, 0);
            check("rst_wdata", bus.ram_wr_data, 0);
            check("rst_strobes", {bus.ram_wr_en, bus.ram_rd_en, bus.ram_rd_ack}, 0);
            check("rst_rsp", {bus.req0_rsp_valid, bus.req1_rsp_valid, bus.req0_rsp_err, bus.req1_rsp_err}, 0);
            check("rst_rsp_data", {bus.req0_rsp_data, bus.req1_rsp_data}, 0);
        end else begin
            m_addr = m_addr_n; m_wdata = m_wdata_n; m_rsp0 = m_rsp0_n; m_rsp1 = m_rsp1_n;
            e_idle       = !m_wait && (cyc >= m_accept_ok);
            e_wait       = m_wait && (cyc >= m_wait_from);
            e_rd_seen    = bus.ram_rd_ready && (cyc != m_ack_cyc);
            e_stale_take = m_stale && e_rd_seen && (e_idle || e_wait);
            if (bus.req0_valid && bus.req1_valid) e_w = (m_ptr == 0) ? 1 : 0;
            else e_w = bus.req1_valid ? 1 : 0;
            e_acc = e_idle && !e_stale_take && !bus.ram_busy && (bus.req0_valid || bus.req1_valid);

            check("ready0", bus.req0_ready, e_acc && e_w == 0);
            check("ready1", bus.req1_ready, e_acc && e_w == 1);
            check("wr_en", bus.ram_wr_en, cyc == m_issue_cyc && m_we);
            check("rd_en", bus.ram_rd_en, cyc == m_issue_cyc && !m_we);
            check("ram_addr", bus.ram_addr, m_addr);
            check("ram_wr_data", bus.ram_wr_data, m_wdata);
            check("rd_ack", bus.ram_rd_ack, cyc == m_ack_cyc);
            check("rsp_valid0", bus.req0_rsp_valid, cyc == m_done_cyc && m_owner == 0);
            check("rsp_valid1", bus.req1_rsp_valid, cyc == m_done_cyc && m_owner == 1);
            check("rsp_err0", bus.req0_rsp_err, cyc == m_err_cyc && m_owner == 0);
            check("rsp_err1", bus.req1_rsp_err, cyc == m_err_cyc && m_owner == 1);
            check("rsp_data0", bus.req0_rsp_data, m_rsp0);
            check("rsp_data1", bus.req1_rsp_data, m_rsp1);

            if (bus.req0_ready) glog.push_back(0);
            if (bus.req1_ready) glog.push_back(1);
            if (bus.ram_rd_ack) ack_count++;

            if (e_acc) begin
                m_owner = e_w;
                m_ptr   = e_w;
                if (e_w == 0) begin
                    m_we = bus.req0_we; m_addr_n = bus.req0_addr; m_wdata_n = bus.req0_wr_data;
                end else begin
                    m_we = bus.req1_we; m_addr_n = bus.req1_addr; m_wdata_n = bus.req1_wr_data;
                end
                m_issue_cyc = cyc + 1;
                if (m_we) m_accept_ok = cyc + 2;
                else begin
                    m_wait = 1; m_wait_from = cyc + 2;
                end
            end else if (e_wait) begin
                if (e_stale_take) begin
                    m_ack_cyc = cyc + 1; m_stale = 0; m_wait_from = cyc + 1;
                end else if (e_rd_seen) begin
                    m_done_cyc = cyc + 1; m_ack_cyc = cyc + 1;
                    if (m_owner == 0) m_rsp0_n = bus.ram_rd_data;
                    else m_rsp1_n = bus.ram_rd_data;
                    m_wait = 0; m_accept_ok = cyc + 2;
                end else if (TO_EN && (cyc - m_wait_from == TO - 1)) begin
                    m_err_cyc = cyc + 1; m_stale = 1; m_wait = 0; m_accept_ok = cyc + 1;
                end
            end else if (e_idle && e_stale_take) begin
                m_ack_cyc = cyc + 1; m_stale = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int n, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int acc);
        acc = -1;
        if (n == 0) begin
            bus.req0_addr = a; bus.req0_wr_data = d; bus.req0_we = we; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_addr = a; bus.req1_wr_data = d; bus.req1_we = we; bus.req1_valid = 1'b1;
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ((n == 0 && bus.req0_ready) || (n == 1 && bus.req1_ready)) begin
                acc = cyc;
                break;
            end
        end
        check($sformatf("accept_req%0d", n), acc >= 0, 1);
        @(posedge clk);
        #1;
        if (n == 0) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, output int at);
        at = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if ((n == 0 && bus.req0_rsp_valid) || (n == 1 && bus.req1_rsp_valid)) begin
                at = cyc;
                break;
            end
        end
        check($sformatf("rsp_seen_req%0d", n), at >= 0, 1);
    endtask

    // ---------------- directed scenarios ----------------
    int t, ta, tb, r, a0;

    initial begin
        bus.req0_addr = '0; bus.req0_wr_data = '0; bus.req0_we = 1'b0; bus.req0_valid = 1'b0;
        bus.req1_addr = '0; bus.req1_wr_data = '0; bus.req1_we = 1'b0; bus.req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", dbg_state, 2'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // write from req0
        send(0, 1'b1, 24'h000100, 16'hBEEF, t);
        @(negedge clk);
        check("wr_issue_cycle", cyc - t, 1);
        check("wr_en_lit", {bus.ram_wr_en, bus.ram_rd_en}, 2'b10);
        check("wr_addr_lit", bus.ram_addr, 24'h000100);
        check("wr_data_lit", bus.ram_wr_data, 16'hBEEF);
        @(negedge clk);
        check("wr_back_idle", dbg_state, 2'd0);

        // read from req1, data after 5 cycles
        ram_lat = 5; ram_dat = 16'h1234;
        send(1, 1'b0, 24'h0000AA, 16'h0000, t);
        wait_rsp(1, r);
        check("rd_latency", r - t, 7);
        check("rd_data_lit", bus.req1_rsp_data, 16'h1234);
        check("rd_ack_lit", bus.ram_rd_ack, 1);
        check("rd_other_quiet", {bus.req0_rsp_valid, bus.req0_rsp_data}, 0);

        // round robin with both requesters continuously valid
        repeat (3) @(posedge clk);
        #1 glog.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 1'b1, ADDR_W'(32'h200 + i), DATA_W'(32'hA00 + i), ta);
            end
            begin
                for (int i = 0; i < 4; i++) send(1, 1'b1, ADDR_W'(32'h300 + i), DATA_W'(32'hB00 + i), tb);
            end
        join
        check("rr_count", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) check($sformatf("rr_order_%0d", i), glog[i], i % 2);

        // backpressure
        repeat (3) @(posedge clk);
        #1;
        bus.ram_busy = 1'b1;
        bus.req0_addr = 24'h000500; bus.req0_wr_data = 16'h0505; bus.req0_we = 1'b1; bus.req0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ready_low", bus.req0_ready, 0);
        end
        @(posedge clk);
        #1 bus.ram_busy = 1'b0;
        @(negedge clk);
        check("bp_accept", bus.req0_ready, 1);
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;

        // reset while a read is waiting
        repeat (3) @(posedge clk);
        #1 ram_lat = 50; ram_dat = 16'h7777;
        send(0, 1'b0, 24'h000300, 16'h0000, t);
        r = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dbg_state == 2'd2) begin
                r = cyc;
                break;
            end
        end
        check("reached_rd_wait", r >= 0, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_state", dbg_state, 2'd0);
        check("rst_mid_outs", {bus.ram_rd_en, bus.ram_wr_en, bus.ram_rd_ack, bus.ram_addr}, 0);
        glog.delete();
        fork
            send(0, 1'b1, 24'h000600, 16'h0606, ta);
            send(1, 1'b1, 24'h000700, 16'h0707, tb);
            begin
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        check("post_rst_first", glog.size() > 0 ? glog[0] : -1, 0);
        check("post_rst_second", glog.size() > 1 ? glog[1] : -1, 1);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // read that times out, late data discarded, then a clean read
        repeat (3) @(posedge clk);
        #1 ram_lat = 20; ram_dat = 16'hDEAD;
        a0 = ack_count;
        send(0, 1'b0, 24'h000400, 16'h0000, t);
        r = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.req0_rsp_err) begin
                r = cyc;
                break;
            end
        end
        check("to_err_latency", r - t, 10);
        check("to_no_valid", bus.req0_rsp_valid, 0);
        r = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ram_rd_ack) begin
                r = cyc;
                break;
            end
        end
        check("stale_ack_cycle", r - t, 22);
        repeat (3) @(negedge clk);
        check("stale_ack_once", ack_count - a0, 1);
        @(posedge clk);
        #1 ram_lat = 3; ram_dat = 16'h5A5A;
        send(0, 1'b0, 24'h000401, 16'h0000, t);
        wait_rsp(0, r);
        check("after_to_data", bus.req0_rsp_data, 16'h5A5A);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
